// File: rtl/shift_word_serializer.sv
// ---------------------------------------------------------------------------
// shift_word_serializer
//
// Turns parallel words into a one-bit-per-cycle stream that drives the
// d/en/dir inputs of a bidirectional shift register. A word is accepted over
// a valid/ready handshake. It is then shifted out MSB-first (dir 0, shift
// left) or LSB-first (dir 1, shift right). An optional programmable idle gap
// follows each word.
//
// Optional feature: define SER_PARITY_EN to append an even-parity bit
// (XOR of all data bits) as an extra final shift cycle. word_done then moves
// to the parity cycle.
//
// Parameters
//   size      word width in bits (>= 2)
//   GAP_W     width of the inter-word gap count
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   in_valid   in   upstream word present
//   in_ready   out  block can accept a word this cycle (IDLE only)
//   in_data    in   word to serialize
//   in_dir     in   0 = shift left / MSB first, 1 = shift right / LSB first
//   in_gap     in   idle cycles to insert after this word
//   out_en     out  shift register enable
//   out_dir    out  shift register direction (held while idle)
//   out_d      out  shift register serial data (0 when out_en = 0)
//   busy       out  word in flight (SHIFT or GAP)
//   word_done  out  one-cycle pulse with the last bit of a word
// ---------------------------------------------------------------------------
module shift_word_serializer #(
    parameter int size  = 4,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [size-1:0]  in_data,
    input  logic             in_dir,
    input  logic [GAP_W-1:0] in_gap,
    output logic             out_en,
    output logic             out_dir,
    output logic             out_d,
    output logic             busy,
    output logic             word_done
);

`ifdef SER_PARITY_EN
    localparam int NBITS = size + 1;
`else
    localparam int NBITS = size;
`endif
    localparam int CNT_W = (NBITS > 2) ? $clog2(NBITS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t             r_state;
    logic [size-1:0]    r_shift;      // remaining data bits, next bit at the outgoing end
    logic               r_dir;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic [CNT_W-1:0]   r_cnt;        // index of the bit currently on out_d
    logic               r_in_ready;
    logic               r_out_en;
    logic               r_out_dir;
    logic               r_out_d;
    logic               r_busy;
    logic               r_word_done;

    logic               w_accept;
    logic [CNT_W-1:0]   w_next_cnt;
    logic               w_shift_bit;
    logic               w_next_bit;

`ifdef SER_PARITY_EN
    logic               r_par;
`endif

    // in_ready is only ever high in IDLE, so it doubles as the accept qualifier.
    assign w_accept    = in_valid && r_in_ready;
    assign w_next_cnt  = r_cnt + 1'b1;
    assign w_shift_bit = r_dir ? r_shift[0] : r_shift[size-1];

`ifdef SER_PARITY_EN
    assign w_next_bit  = (w_next_cnt == LAST_IDX) ? r_par : w_shift_bit;
`else
    assign w_next_bit  = w_shift_bit;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_dir       <= 1'b0;
            r_gap_cnt   <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b0;
            r_out_en    <= 1'b0;
            r_out_dir   <= 1'b0;
            r_out_d     <= 1'b0;
            r_busy      <= 1'b0;
            r_word_done <= 1'b0;
`ifdef SER_PARITY_EN
            r_par       <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    // First cycle after reset lands here with in_ready low;
                    // raising it now gives ready one cycle after release.
                    r_in_ready  <= 1'b1;
                    r_out_en    <= 1'b0;
                    r_out_d     <= 1'b0;
                    r_busy      <= 1'b0;
                    r_word_done <= 1'b0;
                    if (w_accept) begin
                        r_state    <= S_SHIFT;
                        r_dir      <= in_dir;
                        r_out_dir  <= in_dir;
                        r_gap_cnt  <= in_gap;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_out_en   <= 1'b1;
                        // First bit goes out immediately; the shift copy
                        // already has it consumed.
                        r_out_d    <= in_dir ? in_data[0] : in_data[size-1];
                        r_shift    <= in_dir ? (in_data >> 1) : (in_data << 1);
`ifdef SER_PARITY_EN
                        r_par      <= ^in_data;
`endif
                    end
                end

                S_SHIFT: begin
                    if (r_cnt == LAST_IDX) begin
                        r_cnt       <= '0;
                        r_out_en    <= 1'b0;
                        r_out_d     <= 1'b0;
                        r_word_done <= 1'b0;
                        if (r_gap_cnt != '0) begin
                            r_state <= S_GAP;
                        end else begin
                            r_state    <= S_IDLE;
                            r_busy     <= 1'b0;
                            r_in_ready <= 1'b1;
                        end
                    end else begin
                        r_cnt       <= w_next_cnt;
                        r_out_d     <= w_next_bit;
                        r_shift     <= r_dir ? (r_shift >> 1) : (r_shift << 1);
                        r_word_done <= (w_next_cnt == LAST_IDX);
                    end
                end

                S_GAP: begin
                    // Counts the captured gap down to 1; the cycle showing 1
                    // is the last idle cycle of the gap.
                    if (r_gap_cnt <= GAP_W'(1)) begin
                        r_gap_cnt  <= '0;
                        r_state    <= S_IDLE;
                        r_busy     <= 1'b0;
                        r_in_ready <= 1'b1;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_en    = r_out_en;
    assign out_dir   = r_out_dir;
    assign out_d     = r_out_d;
    assign busy      = r_busy;
    assign word_done = r_word_done;

endmodule

// File: tb/tb_shift_word_serializer.sv
// ---------------------------------------------------------------------------
// tb_shift_word_serializer
//
// Drives directed words (MSB/LSB first, back-to-back with gap, reset
// mid-word, parity patterns) followed by randomized traffic. Expected outputs
// come from a word-level model: each accepted word expands into a queue of
// per-cycle expected items (data bits, optional parity, gap cycles) that are
// consumed one per clock. A downstream shift register model rebuilds each
// word from the DUT's serial outputs and is compared to the accepted word.
// ---------------------------------------------------------------------------
module tb_shift_word_serializer;

    localparam int SIZE  = 4;
    localparam int GAP_W = 4;
`ifdef SER_PARITY_EN
    localparam int NB = SIZE + 1;
`else
    localparam int NB = SIZE;
`endif

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [SIZE-1:0]  in_data;
    logic             in_dir;
    logic [GAP_W-1:0] in_gap;
    logic             out_en;
    logic             out_dir;
    logic             out_d;
    logic             busy;
    logic             word_done;

    shift_word_serializer #(
        .size  (SIZE),
        .GAP_W (GAP_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dir    (in_dir),
        .in_gap    (in_gap),
        .out_en    (out_en),
        .out_dir   (out_dir),
        .out_d     (out_d),
        .busy      (busy),
        .word_done (word_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic            en;
        logic            d;
        logic            dir;
        logic            done;
        logic [SIZE-1:0] word;
    } item_t;

    item_t           exp_q[$];
    int              total;
    int              bad;
    int              cyc;
    int              last_acc;
    int              prev_acc;

    logic            exp_en, exp_d, exp_dir, exp_done, exp_busy, exp_ready;
    logic            obs_en, obs_d, obs_dir, obs_ready;
    logic [SIZE-1:0] recon;
    logic [SIZE-1:0] recon_word;
    logic            recon_pending;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", tag, cyc, got, want);
        end
    endtask

    // One clock of stimulus, reference model update and output comparison.
    task automatic cycle(input logic r, input logic v, input logic [SIZE-1:0] dat,
                         input logic dir, input logic [GAP_W-1:0] gap);
        item_t it;
        rst      = r;
        in_valid = v;
        in_data  = dat;
        in_dir   = dir;
        in_gap   = gap;
        @(posedge clk);
        cyc++;
        // Downstream register consumes whatever was on its inputs before this edge.
        if (obs_en === 1'b1)
            recon = obs_dir ? {obs_d, recon[SIZE-1:1]} : {recon[SIZE-2:0], obs_d};
        if (v && !r && obs_ready === 1'b1) begin
            prev_acc = last_acc;
            last_acc = cyc;
        end

        if (r) begin
            exp_q.delete();
            exp_en = 0; exp_d = 0; exp_dir = 0; exp_done = 0; exp_busy = 0; exp_ready = 0;
        end else begin
            if (v && exp_ready) begin
                for (int j = 0; j < SIZE; j++) begin
                    it.en   = 1'b1;
                    it.d    = dir ? dat[j] : dat[SIZE-1-j];
                    it.dir  = dir;
                    it.done = (j == NB - 1);
                    it.word = dat;
                    exp_q.push_back(it);
                end
`ifdef SER_PARITY_EN
                it.en = 1'b1; it.d = ^dat; it.dir = dir; it.done = 1'b1; it.word = dat;
                exp_q.push_back(it);
`endif
                for (int j = 0; j < int'(gap); j++) begin
                    it.en = 1'b0; it.d = 1'b0; it.dir = dir; it.done = 1'b0; it.word = dat;
                    exp_q.push_back(it);
                end
            end
            if (exp_q.size() != 0) begin
                it        = exp_q.pop_front();
                exp_en    = it.en;
                exp_d     = it.d;
                if (it.en) exp_dir = it.dir;
                exp_done  = it.done;
                exp_busy  = 1'b1;
                exp_ready = 1'b0;
                if (it.done) recon_word = it.word;
            end else begin
                exp_en = 0; exp_d = 0; exp_done = 0; exp_busy = 0; exp_ready = 1;
            end
        end

        @(negedge clk);
        obs_en    = out_en;
        obs_d     = out_d;
        obs_dir   = out_dir;
        obs_ready = in_ready;
        check_eq("out_en",    32'(out_en),    32'(exp_en));
        check_eq("out_d",     32'(out_d),     32'(exp_d));
        check_eq("out_dir",   32'(out_dir),   32'(exp_dir));
        check_eq("word_done", 32'(word_done), 32'(exp_done));
        check_eq("busy",      32'(busy),      32'(exp_busy));
        check_eq("in_ready",  32'(in_ready),  32'(exp_ready));
`ifndef SER_PARITY_EN
        if (recon_pending) check_eq("recon", 32'(recon), 32'(recon_word));
`endif
        recon_pending = exp_done;
        $display("cyc=%0d rst=%0b v=%0b data=%0h dir=%0b gap=%0d | en=%0b d=%0b odir=%0b done=%0b busy=%0b rdy=%0b",
                 cyc, r, v, dat, dir, gap, out_en, out_d, out_dir, word_done, busy, in_ready);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, 1'b0, '0);
    endtask

    initial begin
        int n_acc;
        logic            r_r, r_v, r_dir;
        logic [SIZE-1:0] r_dat;
        logic [GAP_W-1:0] r_gap;

        total = 0; bad = 0; cyc = 0; last_acc = 0; prev_acc = 0;
        obs_en = 0; obs_d = 0; obs_dir = 0; obs_ready = 0;
        recon = '0; recon_word = '0; recon_pending = 0;
        exp_en = 0; exp_d = 0; exp_dir = 0; exp_done = 0; exp_busy = 0; exp_ready = 0;
        rst = 1; in_valid = 0; in_data = '0; in_dir = 0; in_gap = '0;

        // Reset for two cycles, then release.
        cycle(1'b1, 1'b0, '0, 1'b0, '0);
        cycle(1'b1, 1'b0, '0, 1'b0, '0);
        idle(1);

        // MSB first, then LSB first, same word.
        cycle(1'b0, 1'b1, 4'b1011, 1'b0, '0);
        idle(6);
        cycle(1'b0, 1'b1, 4'b1011, 1'b1, '0);
        idle(6);

        // Back-to-back with valid held, gap 3.
        n_acc = 0;
        for (int i = 0; i < 30; i++) begin
            if (n_acc < 2) begin
                cycle(1'b0, 1'b1, (n_acc == 0) ? 4'b0001 : 4'b1000, 1'b0, 4'd3);
                if (last_acc == cyc) n_acc++;
            end else begin
                idle(1);
            end
        end
        check_eq("b2b_accepts", 32'(n_acc), 32'd2);
        check_eq("b2b_interval", 32'(last_acc - prev_acc), 32'(NB + 3 + 1));

        // Reset after the second bit of 1111, then a fresh word.
        cycle(1'b0, 1'b1, 4'b1111, 1'b0, '0);
        idle(1);
        cycle(1'b1, 1'b0, '0, 1'b0, '0);
        idle(1);
        cycle(1'b0, 1'b1, 4'b0110, 1'b1, 4'd2);
        idle(8);

        // Parity-interesting pattern (parity bit 0).
        cycle(1'b0, 1'b1, 4'b0011, 1'b0, '0);
        idle(6);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            r_r   = ($urandom_range(0, 99) == 0);
            r_v   = 1'($urandom_range(0, 1));
            r_dat = SIZE'($urandom);
            r_dir = 1'($urandom_range(0, 1));
            r_gap = ($urandom_range(0, 7) == 0) ? GAP_W'(15) : GAP_W'($urandom_range(0, 2));
            cycle(r_r, r_v, r_dat, r_dir, r_gap);
        end
        idle(24);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
